conv_window_sched: RTL

//  Sequences one 3x3 convolution pass over a CHW feature map held in input BRAM.

---
 rtl/cnn_pkg.sv | 23 ++
 rtl/rd_valid_pipe.sv | 33 +++
 rtl/conv_window_sched.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN window scheduler slice.
package cnn_pkg;

    localparam int DIM_W    = 12;
    localparam int STRIDE_W = 2;
    localparam int KSZ      = 3;
    localparam int SUM_W    = DIM_W + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } sched_state_t;

    // Far edge of the next window position: pos + KSZ + stride, widened so it cannot overflow.
    function automatic logic [SUM_W-1:0] win_end(input logic [DIM_W-1:0] pos,
                                                 input logic [STRIDE_W-1:0] stride);
        return SUM_W'(pos) + SUM_W'(KSZ) + SUM_W'(stride);
    endfunction

endpackage

// File: rtl/rd_valid_pipe.sv
// RD_LAT-deep shift register carrying a window tag (MSB = valid) alongside BRAM read latency.
module rd_valid_pipe #(
    parameter int RD_LAT = 2,
    parameter int TAG_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TAG_W-1:0] tag_p0,
    output logic [TAG_W-1:0] tag_out,
    output logic             empty
);

    logic [TAG_W-1:0] tag_p [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) tag_p[i] <= '0;
        end else begin
            tag_p[0] <= tag_p0;
            for (int i = 1; i < RD_LAT; i++) tag_p[i] <= tag_p[i-1];
        end
    end

    assign tag_out = tag_p[RD_LAT-1];

    always_comb begin
        empty = 1'b1;
        for (int i = 0; i < RD_LAT; i++) begin
            if (tag_p[i][TAG_W-1]) empty = 1'b0;
        end
    end

endmodule

// File: rtl/conv_window_sched.sv
// 3x3 convolution window scheduler: address-generator control, credit throttling, window tagging.
// Optional SCHED_PERF_EN adds stall_cnt / win_cnt performance counters.
module conv_window_sched
    import cnn_pkg::*;
#(
    parameter int RD_LAT  = 2,
    parameter int CREDITS = 4,
    parameter int CRED_W  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DIM_W-1:0]    cfg_width,
    input  logic [DIM_W-1:0]    cfg_channel,
    input  logic [STRIDE_W-1:0] cfg_stride,
    output logic                agen_clr,
    output logic                agen_inc,
    output logic                bram_en,
    output logic                win_valid,
    output logic                win_last_ch,
    output logic                win_last_img,
    input  logic                win_ack,
    output logic                busy,
    output logic                done,
    output logic                cfg_err
`ifdef SCHED_PERF_EN
    ,
    output logic [31:0]         stall_cnt,
    output logic [31:0]         win_cnt
`endif
);

    localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(CREDITS);

    sched_state_t        state, state_nxt;
    logic [DIM_W-1:0]    width_q, channel_q;
    logic [STRIDE_W-1:0] stride_q;
    logic [DIM_W-1:0]    col, row, ch;
    logic [CRED_W-1:0]   credits;
    logic                accept, cfg_bad, issue, ack_ok;
    logic                col_wrap, row_wrap, last_ch, last_img;
    logic [2:0]          tag_p0, tag_out;
    logic                pipe_empty;

    assign accept   = (state == S_IDLE) && start;
    assign cfg_bad  = (cfg_stride == '0) || (cfg_width < DIM_W'(KSZ)) || (cfg_channel == '0);
    assign col_wrap = win_end(col, stride_q) > SUM_W'(width_q);
    assign row_wrap = win_end(row, stride_q) > SUM_W'(width_q);
    assign last_ch  = col_wrap && row_wrap;
    assign last_img = last_ch && (ch == channel_q - DIM_W'(1));
    // Spurious acks with nothing outstanding are dropped so the count saturates.
    assign ack_ok   = win_ack && (credits != CRED_FULL);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        agen_clr  = 1'b0;
        issue     = 1'b0;
        done      = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE:  if (start) state_nxt = cfg_bad ? S_DONE : S_CLEAR;
            S_CLEAR: begin
                agen_clr  = 1'b1;
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                issue = (credits != '0);
                if (issue && last_img) state_nxt = S_DRAIN;
            end
            S_DRAIN: if (pipe_empty && (credits == CRED_FULL)) state_nxt = S_DONE;
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bram_en  = issue;
    assign agen_inc = issue;

    always_ff @(posedge clk) begin
        if (accept) begin
            width_q   <= cfg_width;
            channel_q <= cfg_channel;
            stride_q  <= cfg_stride;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)         cfg_err <= 1'b0;
        else if (accept) cfg_err <= cfg_bad;
    end

    // Mirror of the address generator's column/row/channel walk.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            col <= '0;
            row <= '0;
            ch  <= '0;
        end else if (issue) begin
            if (!col_wrap) begin
                col <= col + DIM_W'(stride_q);
            end else begin
                col <= '0;
                if (!row_wrap) begin
                    row <= row + DIM_W'(stride_q);
                end else begin
                    row <= '0;
                    ch  <= ch + DIM_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) credits <= CRED_FULL;
        else     credits <= credits - CRED_W'(issue) + CRED_W'(ack_ok);
    end

    // Issue -> BRAM data: tag travels RD_LAT stages with the read.
    assign tag_p0 = {issue, issue && last_ch, issue && last_img};

    rd_valid_pipe #(
        .RD_LAT (RD_LAT),
        .TAG_W  (3)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_p0  (tag_p0),
        .tag_out (tag_out),
        .empty   (pipe_empty)
    );

    assign win_valid    = tag_out[2];
    assign win_last_ch  = tag_out[2] && tag_out[1];
    assign win_last_img = tag_out[2] && tag_out[0];

`ifdef SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            stall_cnt <= '0;
            win_cnt   <= '0;
        end else begin
            if ((state == S_ISSUE) && (credits == '0)) stall_cnt <= stall_cnt + 32'd1;
            if (issue) win_cnt <= win_cnt + 32'd1;
        end
    end
`endif

endmodule
